mbe_mul_pipe: RTL and testbench

//  Parametrised, pipelined Booth-encoded multiplier engine with valid/ready handshakes on both sides.
//  It replaces the single-shot multiplier wrapper with these additions:
//  - configurable operand width and pipeline depth;
//  - per-transaction signed/unsigned mode and a transaction tag;
//  - a credit-protected output FIFO, giving full throughput under backpressure without loss.

---
 rtl/mbe_mul_pipe_if.sv | 45 ++++
 rtl/mbe_mul_pipe.sv | 214 +++++++++++++++++++++
 tb/tb_mbe_mul_pipe.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mbe_mul_pipe_if.sv
// mbe_mul_pipe_if
//   Operand and result channels of the Booth multiplier engine.
//
//   Handshake rule (both channels): a transfer happens on a rising clk edge
//   where valid && ready are both 1. While valid is high and ready is low the
//   producer holds its payload unchanged. Ready is never derived from valid of
//   the same channel, so there is no combinational loop through the handshake.
//
//   Signals
//     in_valid / in_ready          operand channel handshake
//     in_a, in_b                   multiplicand / multiplier (WIDTH)
//     in_signed                    1: two's complement operands, 0: unsigned
//     in_tag                       tag returned with the result (TAG_W)
//     out_valid / out_ready        result channel handshake
//     out_p                        exact product (2*WIDTH)
//     out_tag                      tag of the result at the FIFO head
//
//   Modports
//     master : operand source + result consumer (stimulus side)
//     slave  : the engine
interface mbe_mul_pipe_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               in_signed;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_p;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    output in_valid, in_a, in_b, in_signed, in_tag, out_ready,
    input  in_ready, out_valid, out_p, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, in_tag, out_ready,
    output in_ready, out_valid, out_p, out_tag
  );
endinterface

// File: rtl/mbe_mul_pipe.sv
// mbe_mul_pipe
//   Pipelined radix-4 modified-Booth multiplier with a credit-protected
//   output FIFO. Each accepted operation is captured into stage 1, the product
//   is formed from stage 1 and carried through STAGES-1 further registers, and
//   it is written into the FIFO STAGES edges after acceptance.
//
//   Ports
//     clk        rising-edge clock
//     rst        asynchronous reset, active low
//     bus        mbe_mul_pipe_if.slave (operand and result channels)
//     busy       any operation in flight or buffered
//     dbg_state  controller state (0 = INIT, 1 = RUN)
//
//   Flow control: credit counts operations in the pipe plus entries in the
//   FIFO. New operations are accepted only while credit < OUT_DEPTH, so every
//   accepted operation already owns a FIFO slot and the pipe never stalls.
module mbe_mul_pipe #(
  parameter int WIDTH     = 16,
  parameter int STAGES    = 3,
  parameter int OUT_DEPTH = 5,
  parameter int TAG_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  mbe_mul_pipe_if.slave     bus,
  output logic              busy,
  output logic              dbg_state
);

  localparam int PW = 2 * WIDTH;
  localparam int EW = WIDTH + 2;
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

  // ---------------------------------------------------------------- control
  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t state;
  state_t state_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_INIT;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:  state_nxt = S_RUN;
      S_RUN:   state_nxt = S_RUN;
      default: state_nxt = S_INIT;
    endcase
  end

  assign dbg_state = state;

  logic [CW-1:0] credit;
  logic          accept;
  logic          pop;
  logic [CW-1:0] count;

  // Ready depends only on registered state, never on in_valid.
  assign bus.in_ready = (state == S_RUN) && (credit < CW'(OUT_DEPTH));
  assign accept       = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (count != '0);
  assign pop          = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   credit <= credit + 1'b1;
        2'b01:   credit <= credit - 1'b1;
        default: credit <= credit;
      endcase
    end
  end

  assign busy = (credit != '0);

  // ------------------------------------------------------------- arithmetic
  // Operands arrive already extended to EW bits, so a signed Booth recode of
  // the extended value gives the exact product for both modes. The two extra
  // bits keep unsigned operands positive and make the digit count whole.
  function automatic logic [PW-1:0] booth_mul(input logic [EW-1:0] a,
                                              input logic [EW-1:0] b);
    logic [2*EW-1:0] acc;
    logic [2*EW-1:0] a_sx;
    logic [2*EW-1:0] pp;
    logic [EW:0]     bx;
    logic [2:0]      grp;
    acc  = '0;
    a_sx = {{EW{a[EW-1]}}, a};
    bx   = {b, 1'b0};
    for (int i = 0; i < EW / 2; i++) begin
      grp = bx[2*i +: 3];
      case (grp)
        3'b001, 3'b010: pp = a_sx;
        3'b011:         pp = a_sx << 1;
        3'b100:         pp = -(a_sx << 1);
        3'b101, 3'b110: pp = -a_sx;
        default:        pp = '0;
      endcase
      acc = acc + (pp << (2 * i));
    end
    return acc[PW-1:0];
  endfunction

  // ---------------------------------------------------------------- stage 1
  logic             v1;
  logic [EW-1:0]    a1;
  logic [EW-1:0]    b1;
  logic [TAG_W-1:0] t1;
  logic [PW-1:0]    p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) v1 <= 1'b0;
    else      v1 <= accept;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a1 <= bus.in_signed ? {{2{bus.in_a[WIDTH-1]}}, bus.in_a} : {2'b00, bus.in_a};
      b1 <= bus.in_signed ? {{2{bus.in_b[WIDTH-1]}}, bus.in_b} : {2'b00, bus.in_b};
      t1 <= bus.in_tag;
    end
  end

  assign p1 = booth_mul(a1, b1);

  // ------------------------------------------------- stages 2..STAGES
  logic             wr_v;
  logic [PW-1:0]    wr_p;
  logic [TAG_W-1:0] wr_t;

  if (STAGES == 1) begin : g_one_stage
    assign wr_v = v1;
    assign wr_p = p1;
    assign wr_t = t1;
  end else begin : g_multi_stage
    logic             v_d [1:STAGES-1];
    logic [PW-1:0]    p_d [1:STAGES-1];
    logic [TAG_W-1:0] t_d [1:STAGES-1];

    // Valid bits shift every cycle; bubbles simply travel as v=0.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 1; i < STAGES; i++) v_d[i] <= 1'b0;
      end else begin
        v_d[1] <= v1;
        for (int i = 2; i < STAGES; i++) v_d[i] <= v_d[i-1];
      end
    end

    always_ff @(posedge clk) begin
      if (v1) begin
        p_d[1] <= p1;
        t_d[1] <= t1;
      end
      for (int i = 2; i < STAGES; i++) begin
        if (v_d[i-1]) begin
          p_d[i] <= p_d[i-1];
          t_d[i] <= t_d[i-1];
        end
      end
    end

    assign wr_v = v_d[STAGES-1];
    assign wr_p = p_d[STAGES-1];
    assign wr_t = t_d[STAGES-1];
  end

  // ------------------------------------------------------------ output FIFO
  logic [PW-1:0]    mem_p [OUT_DEPTH];
  logic [TAG_W-1:0] mem_t [OUT_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (wr_v) begin
      mem_p[wr_ptr] <= wr_p;
      mem_t[wr_ptr] <= wr_t;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_v) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_v, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head is forced to zero when empty so stale storage never shows.
  assign bus.out_p   = bus.out_valid ? mem_p[rd_ptr] : '0;
  assign bus.out_tag = bus.out_valid ? mem_t[rd_ptr] : '0;

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
    !(wr_v && (count == CW'(OUT_DEPTH)) && !pop));

endmodule

// File: tb/tb_mbe_mul_pipe.sv
// tb_mbe_mul_pipe
//   Scoreboard bench for mbe_mul_pipe with WIDTH=8, STAGES=3, OUT_DEPTH=5,
//   TAG_W=4. Expected {tag, product} pairs are queued at acceptance and
//   compared against the FIFO head on every cycle the head is valid.
module tb_mbe_mul_pipe;
  localparam int WIDTH     = 8;
  localparam int PW        = 2 * WIDTH;
  localparam int STAGES    = 3;
  localparam int OUT_DEPTH = 5;
  localparam int TAG_W     = 4;

  // ------------------------------------------------------ clock and reset
  logic clk;
  logic rst;
  logic busy;
  logic dbg_state;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mbe_mul_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  mbe_mul_pipe #(
    .WIDTH(WIDTH), .STAGES(STAGES), .OUT_DEPTH(OUT_DEPTH), .TAG_W(TAG_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .busy(busy),
    .dbg_state(dbg_state)
  );

  // ------------------------------------------------------------ checking
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference product, computed with wide integer arithmetic.
  function automatic logic [PW-1:0] model(input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b,
                                          input logic s);
    longint x;
    longint y;
    x = s ? longint'($signed(a)) : longint'({1'b0, a});
    y = s ? longint'($signed(b)) : longint'({1'b0, b});
    return PW'(x * y);
  endfunction

  // ----------------------------------------------------------- scoreboard
  logic [TAG_W+PW-1:0] exp_q[$];
  int pop_cnt   = 0;
  int first_pop = 0;
  int last_pop  = 0;

  always @(negedge clk) begin
    if (rst && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check("stray_result", bus.out_valid, 1'b0);
      end else begin
        check("head", {bus.out_tag, bus.out_p}, exp_q[0]);
        if (bus.out_ready) begin
          void'(exp_q.pop_front());
          pop_cnt++;
          if (pop_cnt == 1) first_pop = cyc;
          last_pop = cyc;
        end
      end
    end
  end

  // --------------------------------------------------------------- driver
  int acc_count = 0;
  int acc_cyc   = 0;

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic s, input logic [TAG_W-1:0] t);
    int waited;
    waited        = 0;
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_signed = s;
    bus.in_tag    = t;
    @(negedge clk);
    while (!bus.in_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", bus.in_ready, 1'b1);
      bus.in_valid = 1'b0;
    end else begin
      exp_q.push_back({t, model(a, b, s)});
      acc_count++;
      @(posedge clk);
      #1;
      acc_cyc      = cyc;
      bus.in_valid = 1'b0;
    end
  endtask

  // One isolated op: checks latency and the product against a fixed value.
  task automatic op_and_wait(input string tag, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input logic s,
                             input logic [TAG_W-1:0] t, input logic [PW-1:0] want);
    int n;
    n = 0;
    do_op(a, b, s, t);
    @(negedge clk);
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, cyc - acc_cyc, STAGES);
    check({tag, "_p"}, bus.out_p, want);
    check({tag, "_tag"}, bus.out_tag, t);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_empty"}, bus.out_valid, 1'b0);
    check({tag, "_idle"}, busy, 1'b0);
    @(posedge clk);
    #1;
  endtask

  // ------------------------------------------------------------ sequence
  logic t3_done;
  logic t5_done;
  int   stale;
  int   n;

  initial begin
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_signed = 1'b0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    // T1 reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_out_p", bus.out_p, 16'h0000);
    check("rst_out_tag", bus.out_tag, 4'h0);
    check("rst_state", dbg_state, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("init_in_ready", bus.in_ready, 1'b0);
    @(negedge clk);
    check("run_in_ready", bus.in_ready, 1'b1);
    check("run_state", dbg_state, 1'b1);
    @(posedge clk);
    #1;

    // T2 arithmetic and latency
    op_and_wait("u255x255", 8'd255, 8'd255, 1'b0, 4'd1, 16'hFE01);
    op_and_wait("sm1xm1",   8'hFF,  8'hFF,  1'b1, 4'd2, 16'h0001);
    op_and_wait("sm128x127", 8'h80, 8'h7F,  1'b1, 4'd3, 16'hC080);
    op_and_wait("u0x200",   8'd0,   8'd200, 1'b0, 4'd4, 16'h0000);
    op_and_wait("s127x127", 8'h7F,  8'h7F,  1'b1, 4'd5, 16'h3F01);
    drain("t2");

    // T3 backpressure
    bus.out_ready = 1'b0;
    acc_count     = 0;
    pop_cnt       = 0;
    t3_done       = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++)
          do_op(WIDTH'($urandom_range(0, 255)), WIDTH'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)), TAG_W'(i));
        t3_done = 1'b1;
      end
    join_none
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("t3_accepted", acc_count, OUT_DEPTH);
    check("t3_in_ready", bus.in_ready, 1'b0);
    check("t3_busy", busy, 1'b1);
    check("t3_head_tag", bus.out_tag, 4'd0);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    n = 0;
    while (!t3_done && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("t3_all_accepted", acc_count, 10);
    drain("t3");
    check("t3_pops", pop_cnt, 10);

    // T4 streaming
    pop_cnt   = 0;
    first_pop = 0;
    last_pop  = 0;
    for (int i = 0; i < 200; i++)
      do_op(WIDTH'($urandom_range(0, 255)), WIDTH'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), TAG_W'(i));
    drain("t4");
    check("t4_pops", pop_cnt, 200);
    check("t4_span", last_pop - first_pop, 199);

    // T5 random stall
    pop_cnt = 0;
    t5_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          do_op(WIDTH'($urandom_range(0, 255)), WIDTH'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)), TAG_W'(i));
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
        t5_done = 1'b1;
      end
      begin
        while (!t5_done) begin
          @(posedge clk);
          #1 bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain("t5");
    check("t5_pops", pop_cnt, 150);

    // T6 reset mid-flight
    bus.out_ready = 1'b0;
    do_op(8'd10, 8'd20, 1'b0, 4'd1);
    do_op(8'd30, 8'd40, 1'b0, 4'd2);
    do_op(8'd50, 8'd60, 1'b0, 4'd3);
    repeat (4) @(negedge clk);
    check("t6_pre_valid", bus.out_valid, 1'b1);
    #2 rst = 1'b0;
    exp_q.delete();
    #1;
    check("t6_rst_valid", bus.out_valid, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_ready", bus.in_ready, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    bus.out_ready = 1'b1;
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    check("t6_no_stale", stale, 0);
    @(posedge clk);
    #1;
    op_and_wait("t6_s100xm3", 8'd100, 8'hFD, 1'b1, 4'd7, 16'hFED4);
    drain("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
